// File: rtl/test_ex1_pkg.sv
// Shared constants and helpers for the test_ex1 FIR slice.
//
// Contents:
//   W_IN, W_OUT, TAPS, CUR_SHL  default block parameters
//   clog2                       ceiling log2, usable in constant expressions
//   wrap_fit / sat_fit          reduce a full-precision sum to a w-bit signed value
//
// The fit helpers work on a 32-bit signed carrier so that they stay independent of
// the instantiating block's parameters; the caller keeps the low w bits of the result.
package test_ex1_pkg;

    localparam int unsigned W_IN    = 4;
    localparam int unsigned W_OUT   = 6;
    localparam int unsigned TAPS    = 4;
    localparam int unsigned CUR_SHL = 1;

    typedef logic signed [31:0] wide_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Two's-complement wrap: keep the low w bits, re-extend the sign.
    function automatic wide_t wrap_fit(input wide_t x, input int unsigned w);
        wide_t r;
        r = x <<< (32 - w);
        return r >>> (32 - w);
    endfunction

    // Clamp to the w-bit signed range.
    function automatic wide_t sat_fit(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/test_ex1_if.sv
// Sample stream interface for test_ex1.
//
// Signals:
//   a  signed input sample, one per clock (no handshake)
//   c  signed filter output
// Modports:
//   master  drives a, observes c (stream source / bench)
//   slave   observes a, drives c (the filter)
interface test_ex1_if #(
    parameter int unsigned W_IN  = test_ex1_pkg::W_IN,
    parameter int unsigned W_OUT = test_ex1_pkg::W_OUT
);
    logic signed [W_IN-1:0]  a;
    logic signed [W_OUT-1:0] c;

    modport master (output a, input c);
    modport slave  (input a, output c);
endinterface

// File: rtl/tap_delay_line.sv
// Shift register holding the delayed samples of a FIR filter.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, clears every tap
//   d     sample entering the line
//   taps  taps[0] is d delayed by one clock, taps[k] by k+1 clocks
module tap_delay_line #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              d,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= d;
            for (int k = 1; k < int'(DEPTH); k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

endmodule

// File: rtl/test_ex1.sv
// Signed FIR filter with fixed coefficients: the current sample has gain 2^CUR_SHL,
// each of the TAPS-1 delayed samples has gain 1. Defaults give
//   c = 2*a[n] + a[n-1] + a[n-2] + a[n-3].
// One sample is consumed per clock; the output is registered, so c follows the a
// presented on the same edge by one clock.
//
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset: clears history and c
//   bus     test_ex1_if slave: a (input sample), c (registered output)
//
// Configuration:
//   TEST_EX1_SAT_EN  defined: output saturates to the W_OUT signed range;
//                    undefined: output wraps (keeps the low W_OUT bits).
//   Only the output stage differs between the two builds.
module test_ex1 #(
    parameter int unsigned W_IN    = test_ex1_pkg::W_IN,
    parameter int unsigned W_OUT   = test_ex1_pkg::W_OUT,
    parameter int unsigned TAPS    = test_ex1_pkg::TAPS,
    parameter int unsigned CUR_SHL = test_ex1_pkg::CUR_SHL
) (
    input logic       clk,
    input logic       rst,
    test_ex1_if.slave bus
);
    import test_ex1_pkg::*;

    localparam int unsigned DEPTH = TAPS - 1;
    // Wide enough that the weighted sum of all taps can never overflow.
    localparam int unsigned WF    = W_IN + CUR_SHL + clog2(TAPS) + 1;

    logic [DEPTH-1:0][W_IN-1:0] taps;
    logic signed [WF-1:0]       sum;
    logic signed [W_OUT-1:0]    c_d;
    logic signed [W_OUT-1:0]    c_q;

    tap_delay_line #(
        .W     (W_IN),
        .DEPTH (DEPTH)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.a),
        .taps (taps)
    );

    // Every term is sign-extended to WF before it is added.
    always_comb begin
        sum = WF'($signed(bus.a)) <<< CUR_SHL;
        for (int k = 0; k < int'(DEPTH); k++) begin
            sum = sum + WF'($signed(taps[k]));
        end
    end

    always_comb begin
`ifdef TEST_EX1_SAT_EN
        c_d = W_OUT'(sat_fit(wide_t'(sum), W_OUT));
`else
        c_d = W_OUT'(wrap_fit(wide_t'(sum), W_OUT));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign bus.c = c_q;

endmodule

// File: tb/tb_test_ex1.sv
// Self-checking bench for test_ex1 at default parameters: a table of
// {rst, a, expected c} records applied one per clock, followed by an impulse
// sequence that checks tap ordering. Expected overflow values follow the build
// (TEST_EX1_SAT_EN defined or not).
module tb_test_ex1;

    typedef struct {
        logic              rst;
        logic signed [3:0] a;
        logic signed [5:0] exp_c;
        string             name;
    } vec_t;

    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    vec_t vecs[$];

    test_ex1_if bus ();

    test_ex1 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void add(input logic r, input int a, input int exp_c, input string name);
        vec_t v;
        v.rst   = r;
        v.a     = 4'(a);
        v.exp_c = 6'(exp_c);
        v.name  = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic signed [5:0] act,
                         input logic signed [5:0] exp_c);
        n_cmp++;
        if (act !== exp_c) begin
            n_bad++;
            $display("FAIL %s: c=%0d required %0d", name, act, exp_c);
        end
    endtask

    // Drive one sample, clock it, and compare just after the edge.
    task automatic step(input logic r, input logic signed [3:0] a_v, input logic signed [5:0] exp_c,
                        input string name);
        rst   = r;
        bus.a = a_v;
        @(posedge clk);
        #1;
        check(name, bus.c, exp_c);
    endtask

    int ovf_neg;
    int ovf_pos;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.a = 4'sd0;

`ifdef TEST_EX1_SAT_EN
        ovf_neg = -32;
        ovf_pos = 31;
`else
        ovf_neg = 24;
        ovf_pos = -29;
`endif

        // Reset held with a=-1
        add(1, -1, 0, "reset0");
        add(1, -1, 0, "reset1");
        // Step from reset to -1
        add(0, -1, -2, "step_neg0");
        add(0, -1, -3, "step_neg1");
        add(0, -1, -4, "step_neg2");
        add(0, -1, -5, "step_neg3");
        add(0, -1, -5, "step_neg_hold");
        // Step change to 5
        add(0,  5,  7, "step_pos0");
        add(0,  5, 13, "step_pos1");
        add(0,  5, 19, "step_pos2");
        add(0,  5, 25, "step_pos3");
        add(0,  5, 25, "step_pos_hold");
        // Negative overflow: sum settles at -40
        add(0, -8,  -1, "neg_ovf0");
        add(0, -8, -14, "neg_ovf1");
        add(0, -8, -27, "neg_ovf2");
        add(0, -8, ovf_neg, "neg_ovf3");
        add(0, -8, ovf_neg, "neg_ovf_hold");
        // Positive overflow: sum settles at 35
        add(0,  7, -10, "pos_ovf0");
        add(0,  7,   5, "pos_ovf1");
        add(0,  7,  20, "pos_ovf2");
        add(0,  7, ovf_pos, "pos_ovf3");
        add(0,  7, ovf_pos, "pos_ovf_hold");
        // Settle at 5, then a one-edge reset pulse clears history
        add(0,  5, 31, "mid_settle0");
        add(0,  5, 29, "mid_settle1");
        add(0,  5, 27, "mid_settle2");
        add(0,  5, 25, "mid_settle3");
        add(1,  5,  0, "mid_rst");
        add(0,  5, 10, "mid_after0");
        add(0,  5, 15, "mid_after1");
        add(0,  5, 20, "mid_after2");
        add(0,  5, 25, "mid_after3");
        // Reset held high ignores a
        add(1,  7,  0, "rst_hold0");
        add(1, -8,  0, "rst_hold1");
        add(0, -8, -16, "rst_release");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].exp_c, vecs[i].name);
        end

        // Impulse from a cleared line: taps must come out in order 2,1,1,1,0
        step(1'b1, 4'sd0, 6'sd0, "imp_rst");
        step(1'b0, 4'sd1, 6'sd2, "imp0");
        step(1'b0, 4'sd0, 6'sd1, "imp1");
        step(1'b0, 4'sd0, 6'sd1, "imp2");
        step(1'b0, 4'sd0, 6'sd1, "imp3");
        step(1'b0, 4'sd0, 6'sd0, "imp4");

        // Distinct samples: 2*(-3) + 4 + (-2) + 1 = -3
        step(1'b0,  4'sd1,  6'sd2, "mix0");
        step(1'b0, -4'sd2, -6'sd3, "mix1");
        step(1'b0,  4'sd4,  6'sd7, "mix2");
        step(1'b0, -4'sd3, -6'sd3, "mix3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
